shared_port_arbiter: RTL
========================

Name: shared_port_arbiter

Overview:
- Round-robin arbiter that shares one bus resource among NUM_REQ requesters. Example: the memory port shared by instruction fetch, data load and data store.
- Produces two forms of the same grant:
  - a one-hot grant, which feeds the one-hot mux directly;
  - a binary select, which feeds the binary-select mux.
- Holds the grant until the resource reports transaction completion.
- Sits between the requesting pipeline stages and the port mux plus the bus interface.

Parameters:
- NUM_REQ, 3, number of requesters (≥2).
- SEL_WIDTH, $clog2(NUM_REQ), width of the binary select.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level; bit i = requester i.
- done  input  1  one-cycle pulse from the shared resource: the current transaction has completed.
- grant_1h  output  NUM_REQ  one-hot grant; all zero when no grant.
- grant_sel  output  SEL_WIDTH  binary index of the granted requester; 0 when no grant.
- grant_valid  output  1  a grant is active.
- start  output  1  one-cycle pulse in the first cycle of each grant; launches the transaction.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low: when resetn=0 at a rising edge of clk, the block resets.
- Reset state:
  - state=IDLE, rr pointer ptr=0.
  - grant_1h=0, grant_sel=0, grant_valid=0, start=0.
- All outputs are registered. No combinational path from req or done to any output.
- States: IDLE and BUSY.
- IDLE:
  - If req≠0, select the winner as the first set bit scanning cyclically from index ptr upward, wrapping from NUM_REQ-1 to 0.
  - At the next edge:
    - load grant_1h and grant_sel with the winner;
    - set grant_valid=1 and start=1;
    - state→BUSY.
  - If req=0, remain in IDLE with outputs at their reset values (ptr unchanged).
  - done is ignored in IDLE.
- BUSY:
  - grant_1h, grant_sel and grant_valid are held constant. req changes are ignored, including the winner dropping its req.
  - start=1 only in the first BUSY cycle and 0 afterwards.
  - done is sampled in every BUSY cycle, including the first (the start cycle).
  - When done=1, at the next edge:
    - grant_1h=0, grant_sel=0, grant_valid=0;
    - ptr = winner+1, wrapping to 0 when winner=NUM_REQ-1;
    - state→IDLE.
- Latency:
  - req seen in IDLE at cycle t → grant_valid=1 at t+1.
  - done at cycle t → grant_valid=0 at t+1.
- Bubble: every grant is followed by at least one IDLE cycle, so back-to-back grants are separated by one bubble cycle.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0,…
- Requester contract: hold req until its start is seen. A req dropped before being granted is simply not considered.
- Reset mid-transaction: grant is dropped immediately at that edge and ptr returns to 0. The resource must be reset alongside this block.
- Invariants:
  - grant_1h is one-hot when grant_valid=1 and zero otherwise.
  - grant_sel equals the index of the set bit in grant_1h.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - The winner is always the lowest-index asserted req.
  - ptr is not implemented; no rotation.
  - All other timing is unchanged.
- Undefined: round-robin behaviour as specified above.

Test Plan (NUM_REQ=3):
- Reset: hold resetn=0 for 2 cycles with req=3'b111 → all outputs 0 during reset. After release, grant_1h=001, grant_sel=0, start=1 one cycle after the first IDLE cycle.
- Single requester: req=3'b100; done pulsed 3 cycles after start → grant_1h=100 and grant_sel=2 held for 4 cycles; grant_valid=0 the cycle after done; one bubble cycle; re-grant to 2.
- Rotation: req=3'b111 constant; done 1 cycle after each start → grant sequence 0,1,2,0 with one bubble cycle between grants.
- Wrap-around skip: grant requester 2, then req=3'b010 → next grant is 1 (the scan starts at ptr=0 and skips 0).
- done during start: done=1 in the same cycle as start → grant lasts exactly one cycle; done asserted while IDLE has no effect.
- Mid-grant changes: winner drops req while BUSY → grant held until done. Assert resetn=0 mid-BUSY → outputs 0 at the next edge and the next grant comes from ptr=0. With ARB_FIXED_PRIO_EN and req=3'b110 constant → requester 1 is granted every time.

Source files
------------

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter sharing one bus port; grant held until done.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module shared_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int SEL_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   grant_1h,
    output logic [SEL_WIDTH-1:0] grant_sel,
    output logic                 grant_valid,
    output logic                 start
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [NUM_REQ-1:0]   grant_1h_n;
    logic [SEL_WIDTH-1:0] grant_sel_n;
    logic                 grant_valid_n;
    logic                 start_n;
    logic                 win_found;
    logic [SEL_WIDTH-1:0] win_idx;

`ifdef ARB_FIXED_PRIO_EN
    // Scan downward so the lowest asserted index is written last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_found = 1'b1;
                win_idx   = SEL_WIDTH'(k);
            end
        end
    end
`else
    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] ptr_n;

    always_comb begin : rr_scan
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = SEL_WIDTH'(j);
            end
        end
    end
`endif

    always_comb begin
        state_n       = state;
        grant_1h_n    = grant_1h;
        grant_sel_n   = grant_sel;
        grant_valid_n = grant_valid;
        start_n       = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        ptr_n         = ptr;
`endif
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_n             = BUSY;
                    grant_1h_n          = '0;
                    grant_1h_n[win_idx] = 1'b1;
                    grant_sel_n         = win_idx;
                    grant_valid_n       = 1'b1;
                    start_n             = 1'b1;
                end
            end
            BUSY: begin
                if (done) begin
                    state_n       = IDLE;
                    grant_1h_n    = '0;
                    grant_sel_n   = '0;
                    grant_valid_n = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                    if (grant_sel == SEL_WIDTH'(NUM_REQ - 1))
                        ptr_n = '0;
                    else
                        ptr_n = grant_sel + SEL_WIDTH'(1);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            grant_1h    <= '0;
            grant_sel   <= '0;
            grant_valid <= 1'b0;
            start       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr         <= '0;
`endif
        end else begin
            state       <= state_n;
            grant_1h    <= grant_1h_n;
            grant_sel   <= grant_sel_n;
            grant_valid <= grant_valid_n;
            start       <= start_n;
`ifndef ARB_FIXED_PRIO_EN
            ptr         <= ptr_n;
`endif
        end
    end

endmodule
